// File: rtl/dealer_player_port_if.sv
// Player action handshake between the dealer seat port and the player bot.
//   dealer_request_action : dealer -> player, level, an action is wanted
//   output_valid          : player -> dealer, action/make_bet are valid
//   action, make_bet      : player -> dealer, action code and bet amount
//   dealer_acknowledge    : dealer -> player, one-cycle capture strobe
//   invalid_move          : dealer -> player, one-cycle illegal-move strobe
// master = dealer side, slave = player side.
interface dealer_player_port_if;
  logic       dealer_request_action;
  logic       output_valid;
  logic [2:0] action;
  logic [7:0] make_bet;
  logic       dealer_acknowledge;
  logic       invalid_move;

  modport master (
    output dealer_request_action, dealer_acknowledge, invalid_move,
    input  output_valid, action, make_bet
  );

  modport slave (
    input  dealer_request_action, dealer_acknowledge, invalid_move,
    output output_valid, action, make_bet
  );
endinterface

// File: rtl/dealer_player_port.sv
// Dealer-side seat port: requests one action per turn from the player bot,
// captures and acknowledges it, checks it against the betting rules, re-requests
// on an illegal move, and hands the core one resolved move (forced fold/check
// on timeout or too many illegal attempts).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start_turn        : begin a turn (only honoured in IDLE)
//   hand_abort        : abandon the turn, back to IDLE next cycle
//   to_call, player_stack : seat context, sampled on start_turn
//   pif               : player handshake (master side)
//   busy              : high outside IDLE
//   turn_done         : one-cycle strobe, final_* / forced valid
//   final_action, final_amount, forced : resolved move, held until next turn_done
module dealer_player_port #(
  parameter logic [7:0]  MIN_BET     = 8'd2,
  parameter int unsigned MAX_RETRIES = 3,
  parameter logic [15:0] TIMEOUT     = 16'd1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_turn,
  input  logic                        hand_abort,
  input  logic [7:0]                  to_call,
  input  logic [7:0]                  player_stack,
  dealer_player_port_if.master        pif,
  output logic                        busy,
  output logic                        turn_done,
  output logic [2:0]                  final_action,
  output logic [7:0]                  final_amount,
  output logic                        forced
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES) + 1;

  localparam logic [2:0] ACT_NONE   = 3'b000;
  localparam logic [2:0] ACT_FOLD   = 3'b001;
  localparam logic [2:0] ACT_CHECK  = 3'b010;
  localparam logic [2:0] ACT_ALL_IN = 3'b011;
  localparam logic [2:0] ACT_CALL   = 3'b100;
  localparam logic [2:0] ACT_BET    = 3'b110;
  localparam logic [2:0] ACT_RAISE  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_EVAL, S_WAIT_DROP, S_FORCE, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           call_q, call_d;
  logic [7:0]           stack_q, stack_d;
  logic [2:0]           act_q, act_d;
  logic [7:0]           bet_q, bet_d;
  logic                 legal_q, legal_d;
  logic [7:0]           amount_q, amount_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [15:0]          timer_q, timer_d;
  logic                 req_q, req_d;
  logic                 ack_q, ack_d;
  logic                 inv_q, inv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           fin_act_q, fin_act_d;
  logic [7:0]           fin_amt_q, fin_amt_d;
  logic                 forced_q, forced_d;

  logic                 legal_c;
  logic [7:0]           amount_c;
  logic [8:0]           raise_sum_c;

  // Betting-rule check on the latched move; 9-bit sum keeps raise overflow honest.
  assign raise_sum_c = {1'b0, call_q} + {1'b0, bet_q};

  always_comb begin
    legal_c  = 1'b0;
    amount_c = 8'd0;
    case (act_q)
      ACT_FOLD:   legal_c = 1'b1;
      ACT_CHECK:  legal_c = (call_q == 8'd0);
      ACT_CALL: begin
        legal_c  = (call_q != 8'd0) && (call_q <= stack_q);
        amount_c = call_q;
      end
      ACT_BET: begin
        legal_c  = (call_q == 8'd0) && (bet_q >= MIN_BET) && (bet_q <= stack_q);
        amount_c = bet_q;
      end
      ACT_RAISE: begin
        legal_c  = (call_q != 8'd0) && (bet_q >= MIN_BET) &&
                   (raise_sum_c <= {1'b0, stack_q});
        amount_c = raise_sum_c[7:0];
      end
      ACT_ALL_IN: begin
        legal_c  = (stack_q != 8'd0);
        amount_c = stack_q;
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Next state, datapath and registered (Moore) outputs.
  always_comb begin
    state_d   = state_q;
    call_d    = call_q;
    stack_d   = stack_q;
    act_d     = act_q;
    bet_d     = bet_q;
    legal_d   = legal_q;
    amount_d  = amount_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    inv_d     = 1'b0;
    fin_act_d = fin_act_q;
    fin_amt_d = fin_amt_q;
    forced_d  = forced_q;

    case (state_q)
      S_IDLE: begin
        if (start_turn) begin
          state_d = S_REQUEST;
          call_d  = to_call;
          stack_d = player_stack;
          retry_d = '0;
          timer_d = 16'd0;
        end
      end
      S_REQUEST: begin
        timer_d = 16'(timer_q + 16'd1);
        if (pif.output_valid) begin
          state_d = S_EVAL;
          act_d   = pif.action;
          bet_d   = pif.make_bet;
        end else if (timer_q == 16'(TIMEOUT - 16'd1)) begin
          state_d = S_FORCE;
        end
      end
      S_EVAL: begin
        legal_d  = legal_c;
        amount_d = amount_c;
        state_d  = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!pif.output_valid) begin
          if (legal_q) begin
            state_d = S_DONE;
          end else if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
            state_d = S_FORCE;
          end else begin
            state_d = S_REQUEST;
            retry_d = RETRY_W'(retry_q + RETRY_W'(1));
            timer_d = 16'd0;
            inv_d   = 1'b1;
          end
        end
      end
      S_FORCE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; the turn result is left untouched.
    if (hand_abort) begin
      state_d = S_IDLE;
      inv_d   = 1'b0;
    end

    // Result registers change only together with turn_done.
    if (state_d == S_DONE) begin
      if (state_q == S_FORCE) begin
        fin_act_d = (call_q == 8'd0) ? ACT_CHECK : ACT_FOLD;
        fin_amt_d = 8'd0;
        forced_d  = 1'b1;
      end else begin
        fin_act_d = act_q;
        fin_amt_d = amount_q;
        forced_d  = 1'b0;
      end
    end

    req_d  = (state_d == S_REQUEST);
    ack_d  = (state_d == S_EVAL);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      call_q    <= 8'd0;
      stack_q   <= 8'd0;
      act_q     <= ACT_NONE;
      bet_q     <= 8'd0;
      legal_q   <= 1'b0;
      amount_q  <= 8'd0;
      retry_q   <= '0;
      timer_q   <= 16'd0;
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      inv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin_act_q <= ACT_NONE;
      fin_amt_q <= 8'd0;
      forced_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      call_q    <= call_d;
      stack_q   <= stack_d;
      act_q     <= act_d;
      bet_q     <= bet_d;
      legal_q   <= legal_d;
      amount_q  <= amount_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      inv_q     <= inv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fin_act_q <= fin_act_d;
      fin_amt_q <= fin_amt_d;
      forced_q  <= forced_d;
    end
  end

  assign pif.dealer_request_action = req_q;
  assign pif.dealer_acknowledge    = ack_q;
  assign pif.invalid_move          = inv_q;
  assign busy                      = busy_q;
  assign turn_done                 = done_q;
  assign final_action              = fin_act_q;
  assign final_amount              = fin_amt_q;
  assign forced                    = forced_q;

endmodule
